// File: rtl/mc97_pkg.sv
// Shared MC'97 link constants, slot geometry helpers and the status-pair record.
// Pure declarations; no logic, no latency, no flow control.
package mc97_pkg;

  localparam int MC97_FRAME_BITS     = 256;
  localparam int MC97_TAG_BITS       = 16;
  localparam int MC97_SLOT_BITS      = 20;

  localparam int MC97_SLOT_STAT_ADDR = 1;
  localparam int MC97_SLOT_STAT_DATA = 2;
  localparam int MC97_SLOT_LINE1     = 5;

  typedef logic [7:0] mc97_bcnt_t;

  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] data;
  } mc97_stat_t;

  function automatic mc97_bcnt_t mc97_slot_start(input int slot);
    return mc97_bcnt_t'(MC97_TAG_BITS + MC97_SLOT_BITS * (slot - 1));
  endfunction

  // Frame bit index of the slot's final (LSB) bit.
  function automatic mc97_bcnt_t mc97_slot_last(input int slot);
    return mc97_bcnt_t'(int'(mc97_slot_start(slot)) + MC97_SLOT_BITS - 1);
  endfunction

endpackage

// File: rtl/mc97_link_rx.sv
// MC'97 serial-in deframer: SYNC alignment, tag capture, PCM and status slot extraction.
// Outputs registered one clk after the qualifying sdi_stb; no backpressure, one bit per strobe.
module mc97_link_rx
  import mc97_pkg::*;
#(
  parameter int PCM_SLOT = MC97_SLOT_LINE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdi_bit,
  input  logic        sdi_sync,
  input  logic        sdi_stb,
  output logic [15:0] pcm_data,
  output logic        pcm_stb,
  output logic [6:0]  stat_addr,
  output logic [15:0] stat_data,
  output logic        stat_stb,
  output logic        codec_ready,
  output logic        locked,
  output logic        frame_err
);

  localparam logic [1:0] ST_HUNT  = 2'd0;
  localparam logic [1:0] ST_ALIGN = 2'd1;
  localparam logic [1:0] ST_LOCK  = 2'd2;

  localparam mc97_bcnt_t LAST_BIT  = mc97_bcnt_t'(MC97_FRAME_BITS - 1);
  localparam mc97_bcnt_t TAG_LAST  = mc97_bcnt_t'(MC97_TAG_BITS - 1);
  localparam mc97_bcnt_t ADDR_LAST = mc97_slot_last(MC97_SLOT_STAT_ADDR);
  localparam mc97_bcnt_t DATA_LAST = mc97_slot_last(MC97_SLOT_STAT_DATA);
  localparam mc97_bcnt_t PCM_LAST  = mc97_slot_last(PCM_SLOT);
  localparam int         PCM_TAG   = 15 - PCM_SLOT;

  logic [1:0]  state;
  mc97_bcnt_t  bcnt;
  logic        sync_q;
  logic [18:0] shreg;
  logic        tag_stat;
  logic        tag_pcm;
  logic [6:0]  addr_hold;
  mc97_stat_t  stat_q;

  logic        sync_edge;
  logic        at_end;
  logic        frame_ok;
  logic        in_lock;
  mc97_bcnt_t  cur;
  logic [19:0] field;

  // cur is the frame index of the bit arriving on this strobe.
  assign cur       = bcnt + 8'd1;
  assign field     = {shreg, sdi_bit};
  assign sync_edge = sdi_sync & ~sync_q;
  assign at_end    = (cur == LAST_BIT);
  assign frame_ok  = (sync_edge == at_end);
  assign in_lock   = (state == ST_LOCK);

  assign stat_addr = stat_q.addr;
  assign stat_data = stat_q.data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_HUNT;
      bcnt        <= '0;
      // A SYNC already high out of reset must not count as a rising edge.
      sync_q      <= 1'b1;
      shreg       <= '0;
      tag_stat    <= 1'b0;
      tag_pcm     <= 1'b0;
      addr_hold   <= '0;
      stat_q      <= '0;
      pcm_data    <= '0;
      pcm_stb     <= 1'b0;
      stat_stb    <= 1'b0;
      codec_ready <= 1'b0;
      locked      <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      pcm_stb   <= 1'b0;
      stat_stb  <= 1'b0;
      frame_err <= 1'b0;
      if (sdi_stb) begin
        sync_q <= sdi_sync;
        shreg  <= field[18:0];
        case (state)
          ST_HUNT: begin
            if (sync_edge) begin
              state <= ST_ALIGN;
              bcnt  <= LAST_BIT;
            end
          end
          default: begin
            bcnt <= cur;
            if (cur == TAG_LAST) begin
              tag_stat <= field[14] & field[13];
              tag_pcm  <= field[PCM_TAG];
              if (in_lock && frame_ok)
                codec_ready <= field[15];
            end
            if (in_lock && frame_ok) begin
              if (cur == ADDR_LAST)
                addr_hold <= field[18:12];
              if (cur == DATA_LAST && tag_stat) begin
                stat_q.addr <= addr_hold;
                stat_q.data <= field[19:4];
                stat_stb    <= 1'b1;
              end
              if (cur == PCM_LAST && tag_pcm) begin
                pcm_data <= field[19:4];
                pcm_stb  <= 1'b1;
              end
            end
            if (sync_edge && !at_end) begin
              // Early SYNC: restart alignment with this strobe as bit 255.
              frame_err <= 1'b1;
              locked    <= 1'b0;
              state     <= ST_ALIGN;
              bcnt      <= LAST_BIT;
            end else if (at_end && !sync_edge) begin
              frame_err   <= 1'b1;
              locked      <= 1'b0;
              codec_ready <= 1'b0;
              state       <= ST_HUNT;
            end else if (at_end) begin
              locked <= 1'b1;
              state  <= ST_LOCK;
            end
          end
        endcase
      end
    end
  end

endmodule
